// File: rtl/mc_maindec_pkg.sv
// rtl/mc_maindec_pkg.sv - shared opcode, state, and control-code definitions for the main decoder
package mc_maindec_pkg;

   localparam int OP_BITS    = 6;
   localparam int STATE_BITS = 4;

   // Opcodes handled by the multicycle controller
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // State encodings; 12..15 are unused and fall back to FETCH
   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_RTYPEEX = 4'd6;
   localparam logic [3:0] S_RTYPEWB = 4'd7;
   localparam logic [3:0] S_BEQEX   = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JEX     = 4'd11;

   // ALU decoder operation select
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU B-operand select
   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   // Next-PC select
   localparam logic [1:0] PCSRC_ALURES = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Full set of datapath controls produced each cycle
   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] opc);
      return (opc == OP_RTYPE) || (opc == OP_LW) || (opc == OP_SW) ||
             (opc == OP_BEQ) || (opc == OP_ADDI) || (opc == OP_J);
   endfunction

endpackage

// File: rtl/mc_maindec.sv
// rtl/mc_maindec.sv - multicycle MIPS main-decoder FSM driving datapath enables and aluop
module mc_maindec
   import mc_maindec_pkg::*;
#(
   parameter int OP_W    = OP_BITS,
   parameter int STATE_W = STATE_BITS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    op,
   input  logic               memready,
   output logic               pcwrite,
   output logic               branch,
   output logic               iord,
   output logic               memwrite,
   output logic               irwrite,
   output logic               regdst,
   output logic               memtoreg,
   output logic               regwrite,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [1:0]         aluop,
   output logic               instr_done,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state
);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   ctrl_t              ctrl;

   // State register; reset always restarts at instruction fetch
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection; op is only looked at in DECODE and MEMADR
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (memready) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW) begin
               state_d = S_MEMRD;
            end else if (op == OP_SW) begin
               state_d = S_MEMWR;
            end else begin
               // IR cannot change here, but never wedge on a corrupted opcode
               state_d = S_FETCH;
            end
         end
         S_MEMRD: begin
            if (memready) begin
               state_d = S_MEMWB;
            end
         end
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR: begin
            if (memready) begin
               state_d = S_FETCH;
            end
         end
         S_RTYPEEX: state_d = S_RTYPEWB;
         S_RTYPEWB: state_d = S_FETCH;
         S_BEQEX:   state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JEX:     state_d = S_FETCH;
         default:   state_d = S_FETCH;
      endcase
   end

   // Moore output decode with memready gating in the wait states and reset suppression of writes
   always_comb begin
      ctrl = '0;
      case (state_q)
         S_FETCH: begin
            ctrl.iord    = 1'b0;
            ctrl.alusrca = 1'b0;
            ctrl.alusrcb = SRCB_FOUR;
            ctrl.aluop   = ALUOP_ADD;
            ctrl.pcsrc   = PCSRC_ALURES;
            // IR and PC load together exactly on the cycle the fetch completes
            ctrl.irwrite = memready;
            ctrl.pcwrite = memready;
         end
         S_DECODE: begin
            ctrl.alusrca = 1'b0;
            ctrl.alusrcb = SRCB_IMMSH2;
            ctrl.aluop   = ALUOP_ADD;
            if (!is_legal_op(op)) begin
               ctrl.illegal_op = 1'b1;
               ctrl.instr_done = 1'b1;
            end
         end
         S_MEMADR: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
            ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMRD: begin
            ctrl.iord = 1'b1;
         end
         S_MEMWB: begin
            ctrl.regdst     = 1'b0;
            ctrl.memtoreg   = 1'b1;
            ctrl.regwrite   = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_MEMWR: begin
            // Strobe stays up until the memory accepts the write
            ctrl.iord       = 1'b1;
            ctrl.memwrite   = 1'b1;
            ctrl.instr_done = memready;
         end
         S_RTYPEEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_B;
            ctrl.aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            ctrl.regdst     = 1'b1;
            ctrl.memtoreg   = 1'b0;
            ctrl.regwrite   = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_BEQEX: begin
            ctrl.alusrca    = 1'b1;
            ctrl.alusrcb    = SRCB_B;
            ctrl.aluop      = ALUOP_SUB;
            ctrl.pcsrc      = PCSRC_ALUOUT;
            ctrl.branch     = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
            ctrl.aluop   = ALUOP_ADD;
         end
         S_ADDIWB: begin
            ctrl.regdst     = 1'b0;
            ctrl.memtoreg   = 1'b0;
            ctrl.regwrite   = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_JEX: begin
            ctrl.pcsrc      = PCSRC_JUMP;
            ctrl.pcwrite    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         default: begin
            ctrl = '0;
         end
      endcase

      // An instruction interrupted by reset must leave no architectural trace
      if (reset) begin
         ctrl.pcwrite    = 1'b0;
         ctrl.irwrite    = 1'b0;
         ctrl.regwrite   = 1'b0;
         ctrl.memwrite   = 1'b0;
         ctrl.branch     = 1'b0;
         ctrl.instr_done = 1'b0;
         ctrl.illegal_op = 1'b0;
      end
   end

   assign pcwrite    = ctrl.pcwrite;
   assign branch     = ctrl.branch;
   assign iord       = ctrl.iord;
   assign memwrite   = ctrl.memwrite;
   assign irwrite    = ctrl.irwrite;
   assign regdst     = ctrl.regdst;
   assign memtoreg   = ctrl.memtoreg;
   assign regwrite   = ctrl.regwrite;
   assign alusrca    = ctrl.alusrca;
   assign alusrcb    = ctrl.alusrcb;
   assign pcsrc      = ctrl.pcsrc;
   assign aluop      = ctrl.aluop;
   assign instr_done = ctrl.instr_done;
   assign illegal_op = ctrl.illegal_op;
   assign state      = state_q;

endmodule
